// File: rtl/pp_ctrl_h1_if.sv
// Start/valid handshake and arbitration bundle between pp_ctrl_h1 and the hidden-layer-1 neurons.
interface pp_ctrl_h1_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 32
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    // Sequencing inputs
    logic           TU_incre;
    logic           start_core_img;
    logic           any_spike_in;
    logic           li_mode;

    // Per-neuron handshakes and state
    logic [N-1:0]   valid_pp1;
    logic [N-1:0]   valid_pp2;
    logic [N-1:0]   valid_pp3m;
    logic [N-1:0]   valid_pp3;
    logic [N*W-1:0] potential;
    logic [N-1:0]   ref_flags;

    // Controller results
    logic           start_pp1;
    logic           start_pp2;
    logic           start_pp3;
    logic           start_pp3m;
    logic [N-1:0]   won_lost_hold;
    logic [IW-1:0]  winner_idx;
    logic           winner_valid;
    logic           tu_done;
    logic           busy;
    logic           err_timeout;
    logic           err_overrun;

    // Controller (initiator/arbiter) side
    modport master (
        input  TU_incre, start_core_img, any_spike_in, li_mode,
        input  valid_pp1, valid_pp2, valid_pp3m, valid_pp3, potential, ref_flags,
        output start_pp1, start_pp2, start_pp3, start_pp3m, won_lost_hold,
        output winner_idx, winner_valid, tu_done, busy, err_timeout, err_overrun
    );

    // Neuron array / environment side
    modport slave (
        output TU_incre, start_core_img, any_spike_in, li_mode,
        output valid_pp1, valid_pp2, valid_pp3m, valid_pp3, potential, ref_flags,
        input  start_pp1, start_pp2, start_pp3, start_pp3m, won_lost_hold,
        input  winner_idx, winner_valid, tu_done, busy, err_timeout, err_overrun
    );
endinterface

// File: rtl/pp_ctrl_h1.sv
// Per-TU sequencer and winner-take-all arbiter for the hidden-layer-1 neuron array.
module pp_ctrl_h1 #(
    parameter int unsigned N       = 8,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    pp_ctrl_h1_if.master  bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = 12;

    typedef enum logic [2:0] {
        S_IDLE, S_W1, S_W2, S_W3M, S_ARB, S_W3, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          mask_q, mask_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         arb_idx_q, arb_idx_d;
    logic signed [W-1:0]   best_q, best_d;
    logic                  found_q, found_d;
    logic [IW-1:0]         best_idx_q, best_idx_d;

    logic                  start_pp1_q, start_pp1_d;
    logic                  start_pp2_q, start_pp2_d;
    logic                  start_pp3_q, start_pp3_d;
    logic                  start_pp3m_q, start_pp3m_d;
    logic [N-1:0]          wlh_q, wlh_d;
    logic [IW-1:0]         winner_idx_q, winner_idx_d;
    logic                  winner_valid_q, winner_valid_d;
    logic                  tu_done_q, tu_done_d;
    logic                  busy_q, busy_d;
    logic                  err_timeout_q, err_timeout_d;
    logic                  err_overrun_q, err_overrun_d;

    logic [N-1:0]          vsel;
    logic                  all_done;
    logic signed [W-1:0]   pot_sel;
    logic                  eligible;
    logic                  arb_take;
    logic                  found_n;
    logic [IW-1:0]         best_idx_n;

    // Valid vector that the current wait state listens to; the others are ignored
    always_comb begin
        vsel = '0;
        case (state_q)
            S_W1:    vsel = bus.valid_pp1;
            S_W2:    vsel = bus.valid_pp2;
            S_W3M:   vsel = bus.valid_pp3m;
            S_W3:    vsel = bus.valid_pp3;
            default: vsel = '0;
        endcase
    end

    assign all_done = &(mask_q | vsel);

    // One compare step of the serial arbiter; strict > keeps the lower index on ties
    always_comb begin
        pot_sel    = $signed(bus.potential[int'(arb_idx_q) * W +: W]);
        eligible   = !bus.ref_flags[arb_idx_q];
        arb_take   = eligible && (!found_q || (pot_sel > best_q));
        found_n    = found_q | eligible;
        best_idx_n = arb_take ? arb_idx_q : best_idx_q;
    end

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        cnt_d          = cnt_q;
        arb_idx_d      = arb_idx_q;
        best_d         = best_q;
        found_d        = found_q;
        best_idx_d     = best_idx_q;
        start_pp1_d    = 1'b0;
        start_pp2_d    = 1'b0;
        start_pp3_d    = 1'b0;
        start_pp3m_d   = 1'b0;
        tu_done_d      = 1'b0;
        wlh_d          = wlh_q;
        winner_idx_d   = winner_idx_q;
        winner_valid_d = winner_valid_q;
        err_timeout_d  = err_timeout_q;
        // A tick outside IDLE is always dropped and flagged
        err_overrun_d  = err_overrun_q | (bus.TU_incre && (state_q != S_IDLE));

        if (bus.start_core_img) begin
            state_d        = S_IDLE;
            mask_d         = '0;
            cnt_d          = '0;
            arb_idx_d      = '0;
            best_d         = '0;
            found_d        = 1'b0;
            best_idx_d     = '0;
            wlh_d          = '0;
            winner_idx_d   = '0;
            winner_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.TU_incre) begin
                        mask_d = '0;
                        cnt_d  = '0;
                        if (!bus.any_spike_in) begin
                            start_pp1_d = 1'b1;
                            state_d     = S_W1;
                        end else if (bus.li_mode) begin
                            start_pp2_d = 1'b1;
                            state_d     = S_W2;
                        end else begin
                            start_pp3_d = 1'b1;
                            state_d     = S_W3M;
                        end
                    end
                end
                S_W1, S_W2, S_W3M, S_W3: begin
                    mask_d = mask_q | vsel;
                    cnt_d  = cnt_q + CW'(1);
                    if (all_done) begin
                        mask_d = '0;
                        cnt_d  = '0;
                        if (state_q == S_W3M) begin
                            state_d    = S_ARB;
                            arb_idx_d  = '0;
                            best_d     = '0;
                            found_d    = 1'b0;
                            best_idx_d = '0;
                        end else begin
                            state_d   = S_DONE;
                            tu_done_d = 1'b1;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // Abort the TU: no tu_done, back to IDLE
                        err_timeout_d = 1'b1;
                        mask_d        = '0;
                        cnt_d         = '0;
                        wlh_d         = '0;
                        state_d       = S_IDLE;
                    end
                end
                S_ARB: begin
                    found_d    = found_n;
                    best_d     = arb_take ? pot_sel : best_q;
                    best_idx_d = best_idx_n;
                    arb_idx_d  = arb_idx_q + IW'(1);
                    if (arb_idx_q == IW'(N - 1)) begin
                        start_pp3m_d   = 1'b1;
                        wlh_d          = found_n ? (N'(1) << best_idx_n) : '0;
                        winner_idx_d   = best_idx_n;
                        winner_valid_d = found_n;
                        arb_idx_d      = '0;
                        cnt_d          = '0;
                        mask_d         = '0;
                        state_d        = S_W3;
                    end
                end
                S_DONE: begin
                    wlh_d   = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mask_q         <= '0;
            cnt_q          <= '0;
            arb_idx_q      <= '0;
            best_q         <= '0;
            found_q        <= 1'b0;
            best_idx_q     <= '0;
            start_pp1_q    <= 1'b0;
            start_pp2_q    <= 1'b0;
            start_pp3_q    <= 1'b0;
            start_pp3m_q   <= 1'b0;
            wlh_q          <= '0;
            winner_idx_q   <= '0;
            winner_valid_q <= 1'b0;
            tu_done_q      <= 1'b0;
            busy_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            cnt_q          <= cnt_d;
            arb_idx_q      <= arb_idx_d;
            best_q         <= best_d;
            found_q        <= found_d;
            best_idx_q     <= best_idx_d;
            start_pp1_q    <= start_pp1_d;
            start_pp2_q    <= start_pp2_d;
            start_pp3_q    <= start_pp3_d;
            start_pp3m_q   <= start_pp3m_d;
            wlh_q          <= wlh_d;
            winner_idx_q   <= winner_idx_d;
            winner_valid_q <= winner_valid_d;
            tu_done_q      <= tu_done_d;
            busy_q         <= busy_d;
            err_timeout_q  <= err_timeout_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

    assign bus.start_pp1     = start_pp1_q;
    assign bus.start_pp2     = start_pp2_q;
    assign bus.start_pp3     = start_pp3_q;
    assign bus.start_pp3m    = start_pp3m_q;
    assign bus.won_lost_hold = wlh_q;
    assign bus.winner_idx    = winner_idx_q;
    assign bus.winner_valid  = winner_valid_q;
    assign bus.tu_done       = tu_done_q;
    assign bus.busy          = busy_q;
    assign bus.err_timeout   = err_timeout_q;
    assign bus.err_overrun   = err_overrun_q;

endmodule

// File: tb/tb_pp_ctrl_h1.sv
// Directed bench for pp_ctrl_h1: sequencing, WTA arbitration, timeout, overrun, clear and reset.
module tb_pp_ctrl_h1;
    localparam int unsigned N = 8;
    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   pp3m_cnt;
    int   done_cnt;

    pp_ctrl_h1_if #(.N(N), .W(W)) bus ();

    pp_ctrl_h1 #(.N(N), .W(W), .TIMEOUT(4095)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus.start_pp3m) pp3m_cnt++;
        if (bus.tu_done)    done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one TU tick from IDLE; returns in the cycle where start_ppX is visible
    task automatic tu(input logic spike, input logic li);
        bus.TU_incre     = 1'b1;
        bus.any_spike_in = spike;
        bus.li_mode      = li;
        tick();
        bus.TU_incre     = 1'b0;
    endtask

    // Drive all valid_pp3m in one cycle, run arbitration, check latency and result; ends in W3
    task automatic wta(input string tag, input logic [N-1:0] refv,
                       input logic [N-1:0] exp_wlh, input logic [2:0] exp_idx, input logic exp_vld);
        int lat;
        bus.ref_flags = refv;
        tu(1'b1, 1'b0);
        check({tag, "_start_pp3"}, 64'(bus.start_pp3), 64'd1);
        bus.valid_pp3m = '1;
        lat = 0;
        while (!bus.start_pp3m && lat < 50) begin
            tick();
            lat++;
            bus.valid_pp3m = '0;
        end
        check({tag, "_lat"}, 64'(lat), 64'(N + 1));
        check({tag, "_wlh"}, 64'(bus.won_lost_hold), 64'(exp_wlh));
        check({tag, "_wvalid"}, 64'(bus.winner_valid), 64'(exp_vld));
        if (exp_vld) check({tag, "_widx"}, 64'(bus.winner_idx), 64'(exp_idx));
    endtask

    // Complete W3 with all valid_pp3 at once
    task automatic finish_w3(input string tag, input logic [N-1:0] exp_wlh);
        tick();
        check({tag, "_wlh_held"}, 64'(bus.won_lost_hold), 64'(exp_wlh));
        check({tag, "_pp3m_1cyc"}, 64'(bus.start_pp3m), 64'd0);
        bus.valid_pp3 = '1;
        tick();
        bus.valid_pp3 = '0;
        check({tag, "_tu_done"}, 64'(bus.tu_done), 64'd1);
        tick();
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_wlh_clr"}, 64'(bus.won_lost_hold), 64'd0);
    endtask

    initial begin
        int pot_vals[8] = '{5, 90, 90, -3, 40, 0, 7, 1};
        int snap;
        int n;

        n_checks = 0; n_errors = 0; pp3m_cnt = 0; done_cnt = 0;
        rst_n = 1'b0;
        bus.TU_incre = 1'b0; bus.start_core_img = 1'b0;
        bus.any_spike_in = 1'b0; bus.li_mode = 1'b0;
        bus.valid_pp1 = '0; bus.valid_pp2 = '0; bus.valid_pp3m = '0; bus.valid_pp3 = '0;
        bus.ref_flags = '0;
        bus.potential = '0;
        for (int i = 0; i < 8; i++) bus.potential[i*W +: W] = 32'(pot_vals[i] * 4096);

        // Reset state
        tick(); tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_wlh", 64'(bus.won_lost_hold), 64'd0);
        check("rst_errs", 64'({bus.err_timeout, bus.err_overrun}), 64'd0);
        check("rst_pulses", 64'({bus.start_pp1, bus.start_pp2, bus.start_pp3, bus.start_pp3m, bus.tu_done}), 64'd0);
        rst_n = 1'b1;
        tick();

        // pp1: all valids in the first W1 cycle
        tu(1'b0, 1'b0);
        check("pp1_start", 64'({bus.start_pp1, bus.start_pp2, bus.start_pp3}), 64'b100);
        check("pp1_busy", 64'(bus.busy), 64'd1);
        bus.valid_pp1 = '1;
        tick();
        bus.valid_pp1 = '0;
        check("pp1_tu_done", 64'(bus.tu_done), 64'd1);
        check("pp1_start_1cyc", 64'(bus.start_pp1), 64'd0);
        tick();
        check("pp1_idle", 64'({bus.busy, bus.tu_done}), 64'd0);

        // pp2: valids staggered, plus ignored valid_pp1 noise
        snap = pp3m_cnt;
        tu(1'b1, 1'b1);
        check("pp2_start", 64'({bus.start_pp1, bus.start_pp2, bus.start_pp3}), 64'b010);
        for (int i = 0; i < 8; i++) begin
            bus.valid_pp2 = 8'(1 << i);
            bus.valid_pp1 = '1;
            tick();
            bus.valid_pp2 = '0;
            bus.valid_pp1 = '0;
            if (i == 6) check("pp2_not_early", 64'(bus.tu_done), 64'd0);
        end
        check("pp2_tu_done", 64'(bus.tu_done), 64'd1);
        tick();
        check("pp2_no_pp3m", 64'(pp3m_cnt - snap), 64'd0);
        check("pp2_idle", 64'(bus.busy), 64'd0);

        // WTA: tie between 1 and 2 resolves to 1
        wta("wta_tie", 8'h00, 8'b0000_0010, 3'd1, 1'b1);
        finish_w3("wta_tie", 8'b0000_0010);
        // Refractory 1 and 2 -> neuron 4 (40)
        wta("wta_ref12", 8'b0000_0110, 8'b0001_0000, 3'd4, 1'b1);
        finish_w3("wta_ref12", 8'b0001_0000);
        // Only 3 (-3) and 5 (0) eligible: signed compare picks 5
        wta("wta_signed", 8'b1101_0111, 8'b0010_0000, 3'd5, 1'b1);
        finish_w3("wta_signed", 8'b0010_0000);
        // None eligible
        wta("wta_none", 8'hFF, 8'h00, 3'd0, 1'b0);
        finish_w3("wta_none", 8'h00);
        bus.ref_flags = '0;

        // TU with start_core_img in IDLE is dropped
        bus.start_core_img = 1'b1;
        tu(1'b0, 1'b0);
        bus.start_core_img = 1'b0;
        check("img_drop_tu", 64'({bus.busy, bus.start_pp1}), 64'd0);
        check("img_drop_no_ovr", 64'(bus.err_overrun), 64'd0);

        // Timeout: neuron 5 never reports accumulation done
        snap = done_cnt;
        tu(1'b1, 1'b0);
        bus.valid_pp3m = 8'b1101_1111;
        n = 0;
        while (!bus.err_timeout && n < 5000) begin
            tick();
            n++;
        end
        bus.valid_pp3m = '0;
        check("to_cycles", 64'(n), 64'd4095);
        check("to_idle", 64'(bus.busy), 64'd0);
        check("to_no_done", 64'(done_cnt - snap), 64'd0);
        tick();
        check("to_sticky", 64'(bus.err_timeout), 64'd1);

        // Overrun: TU during W3 is dropped and flagged
        wta("ovr", 8'h00, 8'b0000_0010, 3'd1, 1'b1);
        bus.TU_incre = 1'b1;
        tick();
        bus.TU_incre = 1'b0;
        check("ovr_flag", 64'(bus.err_overrun), 64'd1);
        check("ovr_no_start", 64'({bus.start_pp1, bus.start_pp2, bus.start_pp3}), 64'd0);
        check("ovr_wlh_held", 64'(bus.won_lost_hold), 64'b0000_0010);
        bus.valid_pp3 = '1;
        tick();
        bus.valid_pp3 = '0;
        check("ovr_tu_done", 64'(bus.tu_done), 64'd1);
        tick();

        // start_core_img during ARB
        snap = pp3m_cnt;
        tu(1'b1, 1'b0);
        bus.valid_pp3m = '1;
        tick();
        bus.valid_pp3m = '0;
        tick(); tick();
        bus.start_core_img = 1'b1;
        tick();
        bus.start_core_img = 1'b0;
        check("img_idle", 64'(bus.busy), 64'd0);
        check("img_winner_clr", 64'({bus.won_lost_hold, bus.winner_valid}), 64'd0);
        check("img_errs_kept", 64'({bus.err_timeout, bus.err_overrun}), 64'b11);
        repeat (12) tick();
        check("img_no_pp3m", 64'(pp3m_cnt - snap), 64'd0);

        // Async reset while in W3
        wta("rst_w3", 8'h00, 8'b0000_0010, 3'd1, 1'b1);
        tick();
        snap = pp3m_cnt;
        rst_n = 1'b0;
        #1;
        check("arst_wlh", 64'(bus.won_lost_hold), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_errs", 64'({bus.err_timeout, bus.err_overrun}), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.valid_pp3 = '1;
        tick();
        bus.valid_pp3 = '0;
        repeat (3) tick();
        check("arst_no_done", 64'(bus.tu_done), 64'd0);
        check("arst_no_pp3m", 64'(pp3m_cnt - snap), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
